// File: rtl/ram_pkg.sv
// Shared types and encodings for the data-RAM arbiter: FSM states, access
// size codes, the sim-UART address and the alignment check.
package ram_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0]  SZ_B = 2'b00;
   localparam logic [1:0]  SZ_H = 2'b01;
   localparam logic [1:0]  SZ_W = 2'b10;
   localparam int          UBHW_UNSIGNED_BIT = 2;
   localparam logic [31:0] SIM_UART_ADDR = 32'h1000_0000;

   // Half needs addr[0]=0, word needs addr[1:0]=0; bytes are always aligned.
   function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
      return ((sz == SZ_H) && lsb[0]) || ((sz == SZ_W) && (lsb != 2'b00));
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// One requester port of the RAM arbiter: request fields held until ack,
// response fields valid with ack.
interface ram_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [2:0]        ubhw;
   logic              ack;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (output req, we, addr, wdata, ubhw, input ack, err, rdata);
   modport slave  (input req, we, addr, wdata, ubhw, output ack, err, rdata);
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker: on contention the master that
// was not granted last wins.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       gnt,
   output logic       valid
);

   assign valid = |req;
   assign gnt   = (&req) ? ~last : req[1];

endmodule

// File: rtl/ram_arbiter.sv
// Two-master round-robin arbiter and one-cycle access sequencer for the
// byte-addressed data RAM; misaligned accesses never assert ram_we.
module ram_arbiter
   import ram_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clka,
   input  logic              rstn,
   ram_arbiter_if.slave      m0,
   ram_arbiter_if.slave      m1,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   output logic              ram_we,
   output logic [2:0]        ram_ubhw,
   input  logic [DATA_W-1:0] ram_dout,
   output logic              busy
);

   state_t            state, state_nxt;
   logic              last;
   logic              gnt, gnt_vld;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [2:0]        sel_ubhw;

   logic              own_p0, we_p0, mis_p0;
   logic [DATA_W-1:0] rdata0_p1, rdata1_p1;
   logic              err0_p1, err1_p1;

   rr_arb2 u_arb (
      .req   ({m1.req, m0.req}),
      .last  (last),
      .gnt   (gnt),
      .valid (gnt_vld)
   );

   assign sel_we    = gnt ? m1.we    : m0.we;
   assign sel_addr  = gnt ? m1.addr  : m0.addr;
   assign sel_wdata = gnt ? m1.wdata : m0.wdata;
   assign sel_ubhw  = gnt ? m1.ubhw  : m0.ubhw;

   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      ram_we    = 1'b0;
      busy      = 1'b0;
      m0.ack    = 1'b0;
      m1.ack    = 1'b0;
      case (state)
         IDLE:   if (gnt_vld) state_nxt = ACCESS;
         ACCESS: begin
            busy      = 1'b1;
            ram_we    = we_p0 & ~mis_p0;
            state_nxt = RESP;
         end
         RESP: begin
            busy      = 1'b1;
            m0.ack    = ~own_p0;
            m1.ack    = own_p0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Stage p0: grant in IDLE latches the winner's request onto the RAM port.
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         last     <= 1'b1;
         own_p0   <= 1'b0;
         we_p0    <= 1'b0;
         mis_p0   <= 1'b0;
         ram_addr <= '0;
         ram_din  <= '0;
         ram_ubhw <= '0;
      end else if ((state == IDLE) && gnt_vld) begin
         last     <= gnt;
         own_p0   <= gnt;
         we_p0    <= sel_we;
         mis_p0   <= misaligned(sel_ubhw[1:0], sel_addr[1:0]);
         ram_addr <= sel_addr;
         ram_din  <= sel_wdata;
         ram_ubhw <= sel_ubhw;
      end
   end

   // Stage p1: end of ACCESS captures the owner's response; it holds until
   // that master's next RESP.
   always_ff @(posedge clka or negedge rstn) begin
      if (!rstn) begin
         rdata0_p1 <= '0;
         rdata1_p1 <= '0;
         err0_p1   <= 1'b0;
         err1_p1   <= 1'b0;
      end else if (state == ACCESS) begin
         if (own_p0) begin
            rdata1_p1 <= (we_p0 || mis_p0) ? '0 : ram_dout;
            err1_p1   <= mis_p0;
         end else begin
            rdata0_p1 <= (we_p0 || mis_p0) ? '0 : ram_dout;
            err0_p1   <= mis_p0;
         end
      end
   end

   assign m0.rdata = rdata0_p1;
   assign m0.err   = err0_p1;
   assign m1.rdata = rdata1_p1;
   assign m1.err   = err1_p1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a byte-addressed RAM model that
// writes on the falling clock edge and reads combinationally.
module tb_ram_arbiter;
   import ram_pkg::*;

   logic        clka = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] ram_addr, ram_din, ram_dout;
   logic        ram_we, busy;
   logic [2:0]  ram_ubhw;

   int vectors = 0;
   int miscompares = 0;

   ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
   ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();

   ram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clka     (clka),
      .rstn     (rstn),
      .m0       (m0_if),
      .m1       (m1_if),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_we   (ram_we),
      .ram_ubhw (ram_ubhw),
      .ram_dout (ram_dout),
      .busy     (busy)
   );

   always #5 clka = ~clka;

   logic [7:0] mem [0:255];
   logic [7:0] a0, a1, a2, a3;
   int         we_count;
   logic [2:0] we_ubhw;

   assign a0 = ram_addr[7:0];
   assign a1 = a0 + 8'd1;
   assign a2 = a0 + 8'd2;
   assign a3 = a0 + 8'd3;

   always @(negedge clka) begin
      if (ram_we) begin
         we_count = we_count + 1;
         we_ubhw  = ram_ubhw;
         mem[a0] = ram_din[7:0];
         if (ram_ubhw[1:0] != SZ_B) mem[a1] = ram_din[15:8];
         if (ram_ubhw[1:0] == SZ_W) begin
            mem[a2] = ram_din[23:16];
            mem[a3] = ram_din[31:24];
         end
      end
   end

   always_comb begin
      ram_dout = '0;
      case (ram_ubhw[1:0])
         SZ_B: ram_dout = ram_ubhw[UBHW_UNSIGNED_BIT] ? {24'd0, mem[a0]} : {{24{mem[a0][7]}}, mem[a0]};
         SZ_H: ram_dout = ram_ubhw[UBHW_UNSIGNED_BIT] ? {16'd0, mem[a1], mem[a0]}
                                                       : {{16{mem[a1][7]}}, mem[a1], mem[a0]};
         default: ram_dout = {mem[a3], mem[a2], mem[a1], mem[a0]};
      endcase
   end

   // Issue one access from an IDLE cycle (posedge+1) and wait for its ack;
   // returns with the arbiter back in IDLE. lat = -1 if no ack arrived.
   task automatic do_access(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [2:0] ubhw,
                            output int lat, output logic [31:0] rd, output logic er,
                            output logic other_ack);
      lat = -1; rd = '0; er = 1'b0; other_ack = 1'b0;
      if (m == 0) begin
         m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata; m0_if.ubhw = ubhw; m0_if.req = 1'b1;
      end else begin
         m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata; m1_if.ubhw = ubhw; m1_if.req = 1'b1;
      end
      for (int c = 1; c <= 8; c++) begin
         @(posedge clka); #1;
         if ((m == 0) ? m1_if.ack : m0_if.ack) other_ack = 1'b1;
         if ((m == 0) ? m0_if.ack : m1_if.ack) begin
            lat = c;
            rd  = (m == 0) ? m0_if.rdata : m1_if.rdata;
            er  = (m == 0) ? m0_if.err : m1_if.err;
            break;
         end
      end
      m0_if.req = 1'b0;
      m1_if.req = 1'b0;
      @(posedge clka); #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      #1;
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (ram_we !== 1'b0) begin miscompares++; $display("FAIL reset_ram_we: got %b expected 0", ram_we); end
      vectors++; if ({m0_if.ack, m1_if.ack, m0_if.err, m1_if.err} !== 4'b0000) begin
         miscompares++; $display("FAIL reset_ack_err: got %b expected 0000", {m0_if.ack, m1_if.ack, m0_if.err, m1_if.err}); end
      vectors++; if ({ram_addr, ram_din, ram_ubhw} !== 67'd0) begin
         miscompares++; $display("FAIL reset_ram_port: got %h/%h/%b expected 0", ram_addr, ram_din, ram_ubhw); end
      vectors++; if ({m0_if.rdata, m1_if.rdata} !== 64'd0) begin
         miscompares++; $display("FAIL reset_rdata: got %h/%h expected 0", m0_if.rdata, m1_if.rdata); end
      @(posedge clka); @(posedge clka); #1;
      rstn = 1'b1;
      @(posedge clka); #1;
   endtask

   task automatic test_read();
      int lat; logic [31:0] rd; logic er, oth;
      do_access(0, 1'b0, 32'h10, 32'h0, 3'b010, lat, rd, er, oth);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL read_latency: got %0d expected 2", lat); end
      vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL read_rdata: got %h expected deadbeef", rd); end
      vectors++; if (er !== 1'b0) begin miscompares++; $display("FAIL read_err: got %b expected 0", er); end
      vectors++; if (oth !== 1'b0) begin miscompares++; $display("FAIL read_m1_ack: got %b expected 0", oth); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_idle_busy: got %b expected 0", busy); end
   endtask

   task automatic test_write_half();
      int lat; logic [31:0] rd; logic er, oth;
      we_count = 0; we_ubhw = 3'b111;
      do_access(1, 1'b1, 32'h22, 32'h0000A5A5, 3'b001, lat, rd, er, oth);
      vectors++; if (lat !== 2) begin miscompares++; $display("FAIL write_latency: got %0d expected 2", lat); end
      vectors++; if (we_count !== 1) begin miscompares++; $display("FAIL write_we_cycles: got %0d expected 1", we_count); end
      vectors++; if (we_ubhw !== 3'b001) begin miscompares++; $display("FAIL write_ubhw: got %b expected 001", we_ubhw); end
      vectors++; if ({mem[8'h23], mem[8'h22], mem[8'h21]} !== 24'hA5A556) begin
         miscompares++; $display("FAIL write_mem: got %h expected a5a556", {mem[8'h23], mem[8'h22], mem[8'h21]}); end
      vectors++; if ({rd, er} !== 33'd0) begin miscompares++; $display("FAIL write_resp: got %h/%b expected 0/0", rd, er); end
      vectors++; if (m0_if.rdata !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL write_m0_hold: got %h expected deadbeef", m0_if.rdata); end
      do_access(0, 1'b0, 32'h22, 32'h0, 3'b001, lat, rd, er, oth);
      vectors++; if (rd !== 32'hFFFFA5A5) begin miscompares++; $display("FAIL read_half_signed: got %h expected ffffa5a5", rd); end
      do_access(0, 1'b0, 32'h22, 32'h0, 3'b101, lat, rd, er, oth);
      vectors++; if (rd !== 32'h0000A5A5) begin miscompares++; $display("FAIL read_half_unsigned: got %h expected 0000a5a5", rd); end
      do_access(1, 1'b0, 32'h23, 32'h0, 3'b000, lat, rd, er, oth);
      vectors++; if (rd !== 32'hFFFFFFA5) begin miscompares++; $display("FAIL read_byte_signed: got %h expected ffffffa5", rd); end
   endtask

   task automatic test_misalign();
      int lat; logic [31:0] rd; logic er, oth;
      we_count = 0;
      do_access(0, 1'b1, 32'h13, 32'h11223344, 3'b010, lat, rd, er, oth);
      vectors++; if (we_count !== 0) begin miscompares++; $display("FAIL misalign_we: got %0d expected 0", we_count); end
      vectors++; if ({lat, er} !== {32'd2, 1'b1}) begin miscompares++; $display("FAIL misalign_ack_err: got lat %0d err %b expected 2/1", lat, er); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL misalign_rdata: got %h expected 0", rd); end
      vectors++; if ({mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} !== 32'hDEADBEEF) begin
         miscompares++; $display("FAIL misalign_mem: got %h expected deadbeef", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}); end
      do_access(1, 1'b0, 32'h23, 32'h0, 3'b001, lat, rd, er, oth);
      vectors++; if ({er, rd} !== {1'b1, 32'h0}) begin miscompares++; $display("FAIL misalign_half: got err %b rdata %h expected 1/0", er, rd); end
      do_access(1, 1'b0, SIM_UART_ADDR + 32'd2, 32'h0, 3'b010, lat, rd, er, oth);
      vectors++; if (er !== 1'b1) begin miscompares++; $display("FAIL misalign_uart: got %b expected 1", er); end
      vectors++; if (m0_if.err !== 1'b1) begin miscompares++; $display("FAIL misalign_err_hold: got %b expected 1", m0_if.err); end
      do_access(0, 1'b0, 32'h10, 32'h0, 3'b010, lat, rd, er, oth);
      vectors++; if ({er, rd} !== {1'b0, 32'hDEADBEEF}) begin miscompares++; $display("FAIL misalign_recover: got err %b rdata %h expected 0/deadbeef", er, rd); end
   endtask

   task automatic test_back_to_back();
      int n; int cyc [4]; int who [4]; logic [31:0] r1;
      n = 0; r1 = '0;
      rstn = 1'b0; @(posedge clka); #1; rstn = 1'b1;
      m0_if.we = 1'b0; m0_if.addr = 32'h10; m0_if.ubhw = 3'b010; m0_if.req = 1'b1;
      m1_if.we = 1'b0; m1_if.addr = 32'h20; m1_if.ubhw = 3'b010; m1_if.req = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clka); #1;
         if ((m0_if.ack || m1_if.ack) && n < 4) begin
            cyc[n] = c; who[n] = m1_if.ack ? 1 : 0;
            if (m1_if.ack && n == 1) r1 = m1_if.rdata;
            n++;
         end
      end
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      @(posedge clka); #1;
      vectors++; if (n !== 4) begin miscompares++; $display("FAIL rr_ack_count: got %0d expected 4", n); end
      for (int i = 0; i < n; i++) begin
         vectors++;
         if (cyc[i] !== 2 + 3 * i || who[i] !== i % 2) begin
            miscompares++; $display("FAIL rr_grant%0d: got m%0d at cycle %0d expected m%0d at cycle %0d", i, who[i], cyc[i], i % 2, 2 + 3 * i);
         end
      end
      vectors++; if (r1 !== 32'hA5A55678) begin miscompares++; $display("FAIL rr_m1_rdata: got %h expected a5a55678", r1); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] rd; logic er, oth; int first;
      m0_if.we = 1'b1; m0_if.addr = 32'h40; m0_if.wdata = 32'hCAFEF00D; m0_if.ubhw = 3'b010; m0_if.req = 1'b1;
      @(posedge clka); #2;
      vectors++; if (ram_we !== 1'b1) begin miscompares++; $display("FAIL rmid_access_we: got %b expected 1", ram_we); end
      rstn = 1'b0; #1;
      vectors++; if ({busy, ram_we} !== 2'b00) begin miscompares++; $display("FAIL rmid_busy_we: got %b expected 00", {busy, ram_we}); end
      vectors++; if ({ram_addr, ram_din, ram_ubhw} !== 67'd0) begin
         miscompares++; $display("FAIL rmid_ram_port: got %h/%h/%b expected 0", ram_addr, ram_din, ram_ubhw); end
      vectors++; if ({m0_if.rdata, m0_if.err} !== 33'd0) begin
         miscompares++; $display("FAIL rmid_m0_resp: got %h/%b expected 0/0", m0_if.rdata, m0_if.err); end
      m0_if.req = 1'b0;
      oth = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clka); #1;
         if (m0_if.ack || m1_if.ack) oth = 1'b1;
      end
      rstn = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(posedge clka); #1;
         if (m0_if.ack || m1_if.ack) oth = 1'b1;
      end
      vectors++; if (oth !== 1'b0) begin miscompares++; $display("FAIL rmid_no_ack: got %b expected 0", oth); end
      vectors++; if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 32'h0) begin
         miscompares++; $display("FAIL rmid_mem: got %h expected 0", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}); end
      m0_if.we = 1'b0; m0_if.addr = 32'h20; m0_if.ubhw = 3'b010; m0_if.req = 1'b1;
      m1_if.we = 1'b0; m1_if.addr = 32'h10; m1_if.ubhw = 3'b010; m1_if.req = 1'b1;
      first = -1;
      for (int c = 1; c <= 6; c++) begin
         @(posedge clka); #1;
         if (first < 0 && (m0_if.ack || m1_if.ack)) first = m1_if.ack ? 1 : 0;
         if (first >= 0) break;
      end
      m0_if.req = 1'b0; m1_if.req = 1'b0;
      @(posedge clka); #1;
      vectors++; if (first !== 0) begin miscompares++; $display("FAIL rmid_first_grant: got %0d expected 0", first); end
      do_access(0, 1'b1, 32'h40, 32'hCAFEF00D, 3'b010, lat, rd, er, oth);
      vectors++; if ({mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]} !== 32'hCAFEF00D) begin
         miscompares++; $display("FAIL rmid_write_after: got %h expected cafef00d", {mem[8'h43], mem[8'h42], mem[8'h41], mem[8'h40]}); end
   endtask

   initial begin
      m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.wdata = '0; m0_if.ubhw = '0;
      m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.wdata = '0; m1_if.ubhw = '0;
      we_count = 0; we_ubhw = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]} = 32'hDEADBEEF;
      {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]} = 32'h12345678;
      test_reset();
      test_read();
      test_write_half();
      test_misalign();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-master arbiter and access sequencer for the byte-addressed data RAM (u/b/h/w sized accesses, sim-UART at 0x10000000). It sits between two requesters and the single RAM port: master 0 is the core MEM stage, master 1 is the debug/program loader. It grants one access at a time by round-robin, registers the request, drives the RAM for exactly one cycle, and returns registered read data with an acknowledge. Misaligned accesses are rejected before they reach the RAM.

## Interface
Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clka  in  1  clock. The RAM writes on the negedge of this same clock.
- rstn  in  1  asynchronous active-low reset.
- m0_req, m1_req  in  1  access request; held with its fields until ack.
- m0_we, m1_we  in  1  1 = write, 0 = read.
- m0_addr, m1_addr  in  ADDR_W  byte address.
- m0_wdata, m1_wdata  in  DATA_W  write data, right-aligned.
- m0_ubhw, m1_ubhw  in  3  size/sign: [1:0] 00 = byte, 01 = half, 10 = word; [2] 1 = unsigned.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  misaligned; valid with ack.
- m0_rdata, m1_rdata  out  DATA_W  read data; valid with ack.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  DATA_W  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_ubhw  out  3  RAM size/sign.
- ram_dout  in  DATA_W  RAM combinational read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - Sample m0_req and m1_req.
  - If either is high, pick the owner, latch its we/addr/wdata/ubhw, compute the misalign flag, and go to ACCESS.
  - Otherwise stay in IDLE.
- Round-robin pick:
  - One pointer `last` (reset = 1, so master 0 wins first).
  - If both request, grant the master that is not `last`.
  - If only one requests, grant it.
  - `last` is updated on every grant.
- Misalign rule: half with addr[0] = 1, or word with addr[1:0] != 0. The 0x10000000 UART address is subject to the same rule.
- ACCESS:
  - ram_addr, ram_din and ram_ubhw are driven from the latched request.
  - ram_we = latched we AND NOT misalign.
  - At the end of the cycle, rdata is latched as follows: ram_dout if read and aligned; 0 if write or misaligned.
  - err is latched to the misalign flag.
  - Go to RESP.
- RESP:
  - The owner's ack is high for exactly this cycle; its err and rdata are valid.
  - The other master's ack stays 0.
  - Go to IDLE.
- Outside ACCESS, ram_we = 0, and ram_addr, ram_din and ram_ubhw hold their last values.
- rdata and err hold their values until the next RESP for that master.
- Requester rule: req must be low in the cycle after ack unless a new access is intended. Requests are sampled only in IDLE. A req dropped after the grant does not cancel the access.
- Reset (async, any state) puts the block in this state: state = IDLE, last = 1, all ack/err = 0, all rdata = 0, ram_we = 0, ram_addr = 0, ram_din = 0, ram_ubhw = 0, busy = 0. An access in flight is discarded, and a write whose ACCESS cycle has not reached its negedge is not performed.

## Timing
- Request high in IDLE cycle N: ACCESS in cycle N+1 (RAM written at the negedge of N+1); ack, rdata and err in cycle N+2; IDLE in N+3.
- Latency is 2 cycles from sampled req to ack.
- Throughput is one access per 3 cycles.
- With back-to-back contention, masters alternate grants: m0, m1, m0, ...

## Structure
- Shared package `ram_pkg`:
  - state enum (IDLE, ACCESS, RESP).
  - UBHW encodings: SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, and the unsigned-flag bit index.
  - SIM_UART_ADDR = 32'h10000000.
- One sub-module, `rr_arb2`: combinational two-way round-robin picker. Inputs: req[1:0], last. Outputs: gnt index, valid.

## Test plan
- Read: m0 read word at 0x10 with RAM holding 0xDEADBEEF -> m0_ack in cycle N+2, m0_rdata = 0xDEADBEEF, m0_err = 0, m1_ack = 0.
- Write: m1 write half 0xA5A5 at 0x22 -> ram_we high only during ACCESS with ram_ubhw = 001; a subsequent m0 signed half read of 0x22 returns 0xFFFFA5A5.
- Contention: both masters request continuously from reset -> grant order m0, m1, m0, m1; each ack 3 cycles apart.
- Misalign: m0 write word at 0x13 -> ram_we stays 0 throughout, m0_ack with m0_err = 1 and m0_rdata = 0, memory unchanged.
- Reset mid-operation: assert rstn = 0 during ACCESS of a write to 0x40 -> all outputs go to reset values immediately, no ack is issued, and the next access proceeds normally with m0 granted first.
